mem_dbus_master: RTL and testbench



---
 rtl/mem_dbus_master.sv | 208 ++++++++++++++++++++
 tb/tb_mem_dbus_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_master.sv
// MEM-stage data-memory access engine: issues one load/store over a req/ack bus,
// stalls the pipeline until the slave acknowledges, and formats load data for WB.
module mem_dbus_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_excepttype,
    output logic        stallreq_mem,
    output logic [31:0] wdata_o,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state_r;
    logic [31:0] load_q_r;

    logic        is_load_s;
    logic        is_store_s;
    logic [1:0]  size_s;
    logic        aligned_s;
    logic        access_ok_s;
    logic        start_s;
    logic [3:0]  sel_s;
    logic [31:0] store_data_s;

    // Big-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] fmt_load(input logic [7:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'b00:   b = data[31:24];
            2'b01:   b = data[23:16];
            2'b10:   b = data[15:8];
            2'b11:   b = data[7:0];
            default: b = 8'h00;
        endcase
        h = lane[1] ? data[15:0] : data[31:16];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'h000000, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'h0000, h};
            OP_LW:   res = data;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Opcode decode into direction and access size.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        size_s     = SZ_BYTE;
        case (mem_aluop)
            OP_LB, OP_LBU: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            OP_LH, OP_LHU: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            OP_LW:         begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            OP_SB:         begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            OP_SH:         begin is_store_s = 1'b1; size_s = SZ_HALF; end
            OP_SW:         begin is_store_s = 1'b1; size_s = SZ_WORD; end
            default:       begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    // Alignment check, byte enables and lane-replicated store data.
    always_comb begin
        aligned_s    = 1'b0;
        sel_s        = 4'b0000;
        store_data_s = 32'h0000_0000;
        case (size_s)
            SZ_BYTE: begin
                aligned_s    = 1'b1;
                sel_s        = 4'b1000 >> mem_mem_addr[1:0];
                store_data_s = {4{mem_reg2[7:0]}};
            end
            SZ_HALF: begin
                aligned_s    = ~mem_mem_addr[0];
                sel_s        = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
                store_data_s = {2{mem_reg2[15:0]}};
            end
            SZ_WORD: begin
                aligned_s    = (mem_mem_addr[1:0] == 2'b00);
                sel_s        = 4'b1111;
                store_data_s = mem_reg2;
            end
            default: begin
                aligned_s    = 1'b0;
                sel_s        = 4'b0000;
                store_data_s = 32'h0000_0000;
            end
        endcase
    end

    assign access_ok_s = (is_load_s | is_store_s) & (mem_excepttype == 32'h0000_0000) & aligned_s;
    assign start_s     = access_ok_s & ~flush;

    // Stall: a fresh start, an outstanding access, or a new op waiting behind a drain.
    always_comb begin
        case (state_r)
            ST_IDLE:  stallreq_mem = start_s;
            ST_WAIT:  stallreq_mem = 1'b1;
            ST_DRAIN: stallreq_mem = access_ok_s;
            default:  stallreq_mem = 1'b0;
        endcase
    end

    // Result mux toward WB.
    always_comb begin
        if ((state_r == ST_DONE) && is_load_s) begin
            wdata_o = load_q_r;
        end else begin
            wdata_o = mem_wdata;
        end
    end

    // Transaction FSM and bus-side registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'h0000_0000;
            dbus_sel   <= 4'b0000;
            dbus_wdata <= 32'h0000_0000;
            load_q_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store_s;
                        dbus_addr  <= {mem_mem_addr[31:2], 2'b00};
                        dbus_sel   <= sel_s;
                        dbus_wdata <= store_data_s;
                        state_r    <= ST_WAIT;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        if (flush) begin
                            state_r <= ST_IDLE;
                        end else begin
                            if (is_load_s) begin
                                load_q_r <= fmt_load(mem_aluop, mem_mem_addr[1:0], dbus_rdata);
                            end else begin
                                load_q_r <= load_q_r;
                            end
                            state_r <= ST_DONE;
                        end
                    end else if (flush) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_DRAIN;
                    end
                end
                default: begin
                    dbus_req <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dbus_master.sv
// Directed bench for mem_dbus_master: vector table of single accesses plus
// hand sequences for flush/drain and mid-transaction reset.
module tb_mem_dbus_master;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] mem_wdata;
    logic [31:0] mem_excepttype;
    logic        stallreq_mem;
    logic [31:0] wdata_o;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    mem_dbus_master dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_wdata(mem_wdata), .mem_excepttype(mem_excepttype),
        .stallreq_mem(stallreq_mem), .wdata_o(wdata_o),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] wdata;
        logic [31:0] exc;
        logic [31:0] rdata;
        int          delay;
        logic        go;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  sel;
        logic        chk_wd;
        logic [31:0] bwdata;
        logic [31:0] result;
    } vec_t;

    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;
    int   cur    = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): actual=%h required=%h", name, cur, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                input logic [31:0] wdata, input logic [31:0] exc, input logic [31:0] rdata,
                                input int delay, input logic go, input logic we, input logic [31:0] baddr,
                                input logic [3:0] sel, input logic chk_wd, input logic [31:0] bwdata,
                                input logic [31:0] result);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.wdata = wdata; v.exc = exc; v.rdata = rdata;
        v.delay = delay; v.go = go; v.we = we; v.baddr = baddr; v.sel = sel; v.chk_wd = chk_wd;
        v.bwdata = bwdata; v.result = result;
        return v;
    endfunction

    task automatic set_nop();
        mem_aluop = 8'h00; mem_mem_addr = 32'h0; mem_reg2 = 32'h0;
        mem_wdata = 32'h0000_0077; mem_excepttype = 32'h0; flush = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        mem_aluop = v.op; mem_mem_addr = v.addr; mem_reg2 = v.reg2;
        mem_wdata = v.wdata; mem_excepttype = v.exc; flush = 1'b0;
        dbus_rdata = v.rdata;
        dbus_ack = ~v.go;  // ack while idle must be ignored
        @(negedge clk);
        chk("stall_issue", {31'h0, stallreq_mem}, {31'h0, v.go});
        if (!v.go) begin
            chk("passthru", wdata_o, v.wdata);
            repeat (2) begin
                @(negedge clk);
                chk("no_req", {31'h0, dbus_req}, 32'h0);
                chk("no_stall", {31'h0, stallreq_mem}, 32'h0);
            end
            dbus_ack = 1'b0;
        end else begin
            @(posedge clk); #1;
            dbus_ack = (v.delay == 0);
            @(negedge clk);
            chk("req", {31'h0, dbus_req}, 32'h1);
            chk("we", {31'h0, dbus_we}, {31'h0, v.we});
            chk("addr", dbus_addr, v.baddr);
            chk("sel", {28'h0, dbus_sel}, {28'h0, v.sel});
            if (v.chk_wd) chk("bus_wdata", dbus_wdata, v.bwdata);
            chk("stall_wait", {31'h0, stallreq_mem}, 32'h1);
            for (int d = 0; d < v.delay; d++) begin
                @(posedge clk); #1;
                dbus_ack = (d == v.delay - 1);
                @(negedge clk);
                chk("req_held", {31'h0, dbus_req}, 32'h1);
                chk("addr_held", dbus_addr, v.baddr);
                chk("stall_held", {31'h0, stallreq_mem}, 32'h1);
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            @(negedge clk);
            chk("stall_done", {31'h0, stallreq_mem}, 32'h0);
            chk("req_done", {31'h0, dbus_req}, 32'h0);
            chk("result", wdata_o, v.result);
        end
        @(posedge clk); #1;
        set_nop();
        dbus_ack = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(8'hE3, 32'h100, 32'h0,        32'h1111_1111, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF);
        vecs[1]  = mk(8'hE0, 32'h103, 32'h0,        32'h1111_1111, 32'h0, 32'h1234_5680, 0, 1'b1, 1'b0, 32'h100, 4'b0001, 1'b0, 32'h0,        32'hFFFF_FF80);
        vecs[2]  = mk(8'hE4, 32'h103, 32'h0,        32'h1111_1111, 32'h0, 32'h1234_5680, 0, 1'b1, 1'b0, 32'h100, 4'b0001, 1'b0, 32'h0,        32'h0000_0080);
        vecs[3]  = mk(8'hE9, 32'h202, 32'h0000_ABCD, 32'h2222_2222, 32'h0, 32'h0,        3, 1'b1, 1'b1, 32'h200, 4'b0011, 1'b1, 32'hABCD_ABCD, 32'h2222_2222);
        vecs[4]  = mk(8'hE1, 32'h102, 32'h0,        32'h1111_1111, 32'h0, 32'h1234_F678, 0, 1'b1, 1'b0, 32'h100, 4'b0011, 1'b0, 32'h0,        32'hFFFF_F678);
        vecs[5]  = mk(8'hE5, 32'h100, 32'h0,        32'h1111_1111, 32'h0, 32'h8001_5555, 1, 1'b1, 1'b0, 32'h100, 4'b1100, 1'b0, 32'h0,        32'h0000_8001);
        vecs[6]  = mk(8'hE8, 32'h101, 32'h1234_56A5, 32'h3333_3333, 32'h0, 32'h0,        1, 1'b1, 1'b1, 32'h100, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h3333_3333);
        vecs[7]  = mk(8'hEB, 32'h3FC, 32'hCAFE_F00D, 32'h4444_4444, 32'h0, 32'h0,        2, 1'b1, 1'b1, 32'h3FC, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h4444_4444);
        vecs[8]  = mk(8'hE3, 32'h100, 32'h0,        32'h5555_0001, 32'h8, 32'h0,        0, 1'b0, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,        32'h0);
        vecs[9]  = mk(8'hE1, 32'h101, 32'h0,        32'h5555_0002, 32'h0, 32'h0,        0, 1'b0, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,        32'h0);
        vecs[10] = mk(8'h20, 32'h100, 32'h0,        32'h5555_0003, 32'h0, 32'h0,        0, 1'b0, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,        32'h0);
        vecs[11] = mk(8'hE3, 32'h102, 32'h0,        32'h5555_0004, 32'h0, 32'h0,        0, 1'b0, 1'b0, 32'h0,   4'b0000, 1'b0, 32'h0,        32'h0);
        vecs[12] = mk(8'hE0, 32'h100, 32'h0,        32'h1111_1111, 32'h0, 32'h7F00_0000, 0, 1'b1, 1'b0, 32'h100, 4'b1000, 1'b0, 32'h0,        32'h0000_007F);

        rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        set_nop();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req", {31'h0, dbus_req}, 32'h0);
        chk("rst_stall", {31'h0, stallreq_mem}, 32'h0);
        chk("rst_addr", dbus_addr, 32'h0);
        chk("rst_sel", {28'h0, dbus_sel}, 32'h0);
        chk("rst_wdata_o", wdata_o, 32'h0000_0077);

        for (int i = 0; i < 13; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Flush in WAIT, then a new SW arrives while draining.
        cur = 100;
        @(posedge clk); #1;
        mem_aluop = 8'hE3; mem_mem_addr = 32'h40; mem_wdata = 32'h9999_0000;
        @(negedge clk);
        chk("fl_stall_issue", {31'h0, stallreq_mem}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_req", {31'h0, dbus_req}, 32'h1);
        chk("fl_stall_wait", {31'h0, stallreq_mem}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b0;
        mem_aluop = 8'hEB; mem_mem_addr = 32'h80; mem_reg2 = 32'h0102_0304; mem_wdata = 32'h6666_6666;
        @(negedge clk);
        chk("dr_req_up", {31'h0, dbus_req}, 32'h1);
        chk("dr_addr_old", dbus_addr, 32'h40);
        chk("dr_we_old", {31'h0, dbus_we}, 32'h0);
        chk("dr_stall_new", {31'h0, stallreq_mem}, 32'h1);
        @(posedge clk); #1;
        dbus_ack = 1'b1; dbus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("dr_req_up2", {31'h0, dbus_req}, 32'h1);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("dr_idle_req", {31'h0, dbus_req}, 32'h0);
        chk("dr_idle_stall", {31'h0, stallreq_mem}, 32'h1);
        chk("dr_discard", wdata_o, 32'h6666_6666);
        @(posedge clk); #1;
        dbus_ack = 1'b1;
        @(negedge clk);
        chk("sw_req", {31'h0, dbus_req}, 32'h1);
        chk("sw_we", {31'h0, dbus_we}, 32'h1);
        chk("sw_addr", dbus_addr, 32'h80);
        chk("sw_sel", {28'h0, dbus_sel}, 32'hF);
        chk("sw_wdata", dbus_wdata, 32'h0102_0304);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("sw_done_stall", {31'h0, stallreq_mem}, 32'h0);
        chk("sw_done_out", wdata_o, 32'h6666_6666);
        @(posedge clk); #1;
        set_nop();

        // Flush coinciding with ack: straight back to IDLE, data discarded.
        cur = 101;
        @(posedge clk); #1;
        mem_aluop = 8'hE3; mem_mem_addr = 32'h44;
        @(posedge clk); #1;
        flush = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        set_nop(); dbus_ack = 1'b0;
        @(negedge clk);
        chk("fa_req", {31'h0, dbus_req}, 32'h0);
        chk("fa_stall", {31'h0, stallreq_mem}, 32'h0);
        chk("fa_out", wdata_o, 32'h0000_0077);

        // Reset asserted mid-transaction.
        cur = 102;
        @(posedge clk); #1;
        mem_aluop = 8'hE3; mem_mem_addr = 32'h100;
        @(posedge clk); #1;
        rst = 1'b0; set_nop();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_req", {31'h0, dbus_req}, 32'h0);
        chk("mr_stall", {31'h0, stallreq_mem}, 32'h0);
        chk("mr_we", {31'h0, dbus_we}, 32'h0);
        chk("mr_addr", dbus_addr, 32'h0);
        chk("mr_sel", {28'h0, dbus_sel}, 32'h0);
        chk("mr_wdata", dbus_wdata, 32'h0);
        cur = 0;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
